// File: rtl/ecc_seq_pkg.sv
// Shared types and constants for the ecc_top command sequencer.
// Register offsets, op codes, AHB encodings and the sequencer FSM state enum.
package ecc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_D,
        ST_RD_A,
        ST_RD_D,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] ECC_OP_NONE   = 2'd0;
    localparam logic [1:0] ECC_OP_KEYGEN = 2'd1;
    localparam logic [1:0] ECC_OP_SIGN   = 2'd2;
    localparam logic [1:0] ECC_OP_VERIFY = 2'd3;

    localparam logic [31:0] ECC_CTRL_OFF   = 32'h10;
    localparam logic [31:0] ECC_STATUS_OFF = 32'h18;
    localparam int          STATUS_VALID_BIT = 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    function automatic logic op_legal(input logic [1:0] op);
        return (op == ECC_OP_KEYGEN) || (op == ECC_OP_SIGN) || (op == ECC_OP_VERIFY);
    endfunction

endpackage

// File: rtl/ecc_seq_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, zero latency.
// Priority flips to the loser only when advance_i confirms the grant was taken.
module ecc_seq_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = 2'b00;
        prio_d  = prio_q;
        if (req_i[prio_q]) begin
            grant_o[prio_q] = 1'b1;
        end else if (req_i[~prio_q]) begin
            grant_o[~prio_q] = 1'b1;
        end
        // grant_o[0] set means requester 0 won, so requester 1 gets priority next
        if (advance_i && (grant_o != 2'b00)) begin
            prio_d = grant_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ecc_cmd_sequencer.sv
// Arbitrates two requesters onto one ecc_top: CTRL write, STATUS poll until VALID, respond.
// Zero-wait slave, VALID on first poll: accept -> response in 5 cycles; requesters hold req while busy.
module ecc_cmd_sequencer
    import ecc_seq_pkg::*;
#(
    parameter int                        AHB_ADDR_WIDTH = 32,
    parameter int                        AHB_DATA_WIDTH = 32,
    parameter logic [AHB_ADDR_WIDTH-1:0] ECC_BASE_ADDR  = 'h1000_8000,
    parameter int                        POLL_GAP       = 4,
    parameter int                        TIMEOUT_CYCLES = 1_048_576
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid_i,
    input  logic [3:0]                req_op_i,
    output logic [1:0]                req_ready_o,
    output logic [1:0]                rsp_valid_o,
    output logic                      rsp_err_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    output logic                      hsel_o,
    output logic                      hwrite_o,
    output logic                      hready_o,
    output logic [1:0]                htrans_o,
    output logic [2:0]                hsize_o,
    input  logic                      hresp_i,
    input  logic                      hreadyout_i,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    output logic                      busy_o
);

    localparam logic [AHB_ADDR_WIDTH-1:0] CTRL_ADDR   = ECC_BASE_ADDR + AHB_ADDR_WIDTH'(ECC_CTRL_OFF);
    localparam logic [AHB_ADDR_WIDTH-1:0] STATUS_ADDR = ECC_BASE_ADDR + AHB_ADDR_WIDTH'(ECC_STATUS_OFF);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [1:0]    op_q, op_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;
    logic [1:0]    grant;
    logic          arb_adv;
    logic          to_hit;
    logic [1:0]    grant_op;
    logic          unused_rdata;

    assign unused_rdata = ^hrdata_i;
    assign to_hit   = (to_q >= TO_LIMIT);
    assign grant_op = grant[1] ? req_op_i[3:2] : req_op_i[1:0];
    assign hready_o = hreadyout_i;
    assign hsize_o  = HSIZE_WORD;
    assign busy_o   = (state_q != ST_IDLE);

    ecc_seq_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_valid_i),
        .advance_i (arb_adv),
        .grant_o   (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        op_d        = op_q;
        gap_d       = gap_q;
        to_d        = to_q;
        arb_adv     = 1'b0;
        req_ready_o = 2'b00;
        rsp_valid_o = 2'b00;
        rsp_err_o   = 1'b0;
        haddr_o     = '0;
        hwdata_o    = '0;
        hsel_o      = 1'b0;
        hwrite_o    = 1'b0;
        htrans_o    = HTRANS_IDLE;

        // Saturating timeout counter runs only while a command owns the engine
        if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR) && !to_hit) begin
            to_d = to_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((grant != 2'b00) && !reset) begin
                    arb_adv     = 1'b1;
                    req_ready_o = grant;
                    owner_d     = grant[1];
                    op_d        = grant_op;
                    to_d        = '0;
                    state_d     = op_legal(grant_op) ? ST_WR_A : ST_ERR;
                end
            end
            ST_WR_A: begin
                haddr_o  = CTRL_ADDR;
                htrans_o = HTRANS_NONSEQ;
                hwrite_o = 1'b1;
                hsel_o   = 1'b1;
                if (hreadyout_i) state_d = ST_WR_D;
            end
            ST_WR_D: begin
                hwdata_o = AHB_DATA_WIDTH'(op_q);
                if (hreadyout_i) begin
                    state_d = (hresp_i || to_hit) ? ST_ERR : ST_RD_A;
                end
            end
            ST_RD_A: begin
                haddr_o  = STATUS_ADDR;
                htrans_o = HTRANS_NONSEQ;
                hsel_o   = 1'b1;
                if (hreadyout_i) state_d = ST_RD_D;
            end
            ST_RD_D: begin
                if (hreadyout_i) begin
                    if (hresp_i) begin
                        state_d = ST_ERR;
                    end else if (hrdata_i[STATUS_VALID_BIT]) begin
                        state_d = ST_DONE;
                    end else if (to_hit) begin
                        state_d = ST_ERR;
                    end else begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (to_hit) begin
                    state_d = ST_ERR;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ST_RD_A;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: begin
                rsp_valid_o = owner_q ? 2'b10 : 2'b01;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                rsp_valid_o = owner_q ? 2'b10 : 2'b01;
                rsp_err_o   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            op_q    <= ECC_OP_NONE;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_ecc_cmd_sequencer.sv
// Bench for ecc_cmd_sequencer: directed scenarios, a bus-slave responder, and a
// transaction-level expectation model checked every cycle by one monitor process.
module tb_ecc_cmd_sequencer;

    localparam int          POLL_GAP = 4;
    localparam int          TIMEOUT  = 64;
    localparam logic [31:0] CTRL_A   = 32'h1000_8010;
    localparam logic [31:0] STAT_A   = 32'h1000_8018;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        int   owner;
        logic err;
        int   lat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid_i = 2'b00;
    logic [3:0]  req_op_i = 4'b0000;
    logic [1:0]  req_ready_o;
    logic [1:0]  rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] haddr_o;
    logic [31:0] hwdata_o;
    logic        hsel_o;
    logic        hwrite_o;
    logic        hready_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o;
    logic        hresp_i;
    logic        hreadyout_i = 1'b1;
    logic [31:0] hrdata_i;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ecc_cmd_sequencer #(
        .POLL_GAP       (POLL_GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_op_i    (req_op_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_err_o   (rsp_err_o),
        .haddr_o     (haddr_o),
        .hwdata_o    (hwdata_o),
        .hsel_o      (hsel_o),
        .hwrite_o    (hwrite_o),
        .hready_o    (hready_o),
        .htrans_o    (htrans_o),
        .hsize_o     (hsize_o),
        .hresp_i     (hresp_i),
        .hreadyout_i (hreadyout_i),
        .hrdata_i    (hrdata_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave: VALID appears on the sl_valid_after-th STATUS read of a command (0 = never)
    int   sl_valid_after = 1;
    logic sl_wr_err = 1'b0;
    logic s_wr_q, s_rd_q;
    int   s_rds;

    always @(posedge clk) begin
        if (reset) begin
            s_wr_q <= 1'b0;
            s_rd_q <= 1'b0;
            s_rds  <= 0;
        end else if (hreadyout_i) begin
            s_wr_q <= hsel_o && (htrans_o == 2'b10) && hwrite_o;
            s_rd_q <= hsel_o && (htrans_o == 2'b10) && !hwrite_o;
            if (s_wr_q) s_rds <= 0;
            else if (s_rd_q) s_rds <= s_rds + 1;
        end
    end

    assign hresp_i  = s_wr_q && sl_wr_err;
    assign hrdata_i = (s_rd_q && (sl_valid_after != 0) && (s_rds + 1 >= sl_valid_after)) ? 32'h2 : 32'h0;

    // Expectation model state
    xfer_t x_q[$];
    rsp_t  rsp_q[$];
    int    g_q[$];
    bit    any_reads = 1'b0;
    int    rr_last = 1;

    // Monitor observations
    bit          in_flight = 1'b0;
    bit          wr_dph = 1'b0;
    logic [31:0] wr_dat_exp;
    logic [31:0] last_wr_addr, last_wr_data;
    int          mon_rds = 0;
    int          last_rd_cyc = 0;
    int          acc_cyc = 0;
    int          last_lat = -1;
    logic        last_err = 1'b0;
    int          last_owner = -1;

    always @(negedge clk) begin
        if (reset) begin
            in_flight = 1'b0;
            wr_dph    = 1'b0;
        end else begin
            chk("busy", 32'(busy_o), 32'(in_flight));
            chk("hready_passthru", 32'(hready_o), 32'(hreadyout_i));
            chk("hsize", 32'(hsize_o), 32'h2);
            chk("htrans_legal", 32'((htrans_o == 2'b00) || (htrans_o == 2'b10)), 32'h1);
            chk("ready_rsp_exclusive", 32'((req_ready_o != 0) && (rsp_valid_o != 0)), 32'h0);
            if (wr_dph) begin
                chk("ctrl_wdata", hwdata_o, wr_dat_exp);
                last_wr_data = hwdata_o;
                wr_dph = 1'b0;
            end
            if ((htrans_o == 2'b10) && hreadyout_i) begin
                chk("hsel_addr_phase", 32'(hsel_o), 32'h1);
                if (x_q.size() != 0) begin
                    xfer_t e;
                    e = x_q.pop_front();
                    chk("xfer_addr", haddr_o, e.addr);
                    chk("xfer_write", 32'(hwrite_o), 32'(e.wr));
                    if (e.wr) begin
                        wr_dph = 1'b1;
                        wr_dat_exp = e.data;
                        last_wr_addr = haddr_o;
                        mon_rds = 0;
                    end
                end else begin
                    chk("xfer_expected", 32'(any_reads && !hwrite_o), 32'h1);
                    chk("poll_addr", haddr_o, STAT_A);
                end
                if (!hwrite_o) begin
                    if (mon_rds > 0) chk("poll_spacing", 32'(cyc - last_rd_cyc), 32'(POLL_GAP + 2));
                    last_rd_cyc = cyc;
                    mon_rds++;
                end
            end
            if (req_ready_o != 0) begin
                chk("grant_expected", 32'(g_q.size() != 0), 32'h1);
                if (g_q.size() != 0) chk("grant", 32'(req_ready_o), 32'(1) << g_q.pop_front());
                acc_cyc = cyc;
            end
            if (rsp_valid_o != 0) begin
                chk("rsp_expected", 32'(rsp_q.size() != 0), 32'h1);
                if (rsp_q.size() != 0) begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    last_lat   = cyc - acc_cyc;
                    last_err   = rsp_err_o;
                    last_owner = rsp_valid_o[1] ? 1 : 0;
                    chk("rsp_owner", 32'(rsp_valid_o), 32'(1) << r.owner);
                    chk("rsp_err", 32'(rsp_err_o), 32'(r.err));
                    if (r.lat >= 0) chk("rsp_latency", 32'(last_lat), 32'(r.lat));
                    else chk("timeout_latency_in_range",
                             32'((last_lat >= TIMEOUT) && (last_lat <= TIMEOUT + POLL_GAP + 4)), 32'h1);
                end
            end
            if (req_ready_o != 0) in_flight = 1'b1;
            if (rsp_valid_o != 0) in_flight = 1'b0;
        end
    end

    task automatic flush_model();
        x_q.delete();
        rsp_q.delete();
        g_q.delete();
        any_reads = 1'b0;
        rr_last = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid_i = 2'b00;
        hreadyout_i = 1'b1;
        flush_model();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive until n responses; a requester drops valid once its accept has been clocked
    task automatic serve(input int n);
        int got = 0;
        int cycles = 0;
        logic [1:0] drop;
        while ((got < n) && (cycles < 300)) begin
            @(negedge clk);
            drop = req_ready_o;
            if (rsp_valid_o != 0) got++;
            @(posedge clk);
            #1 req_valid_i = req_valid_i & ~drop;
            cycles++;
        end
        chk("serve_completed", 32'(got), 32'(n));
    endtask

    task automatic launch(input logic [1:0] mask, input logic [1:0] op0, input logic [1:0] op1,
                          input int va, input logic werr);
        int order[$];
        logic [1:0] ops[2];
        ops[0] = op0;
        ops[1] = op1;
        sl_valid_after = va;
        sl_wr_err = werr;
        if (mask == 2'b11) begin
            if (rr_last == 0) begin order.push_back(1); order.push_back(0); end
            else begin order.push_back(0); order.push_back(1); end
        end else begin
            order.push_back(mask[1] ? 1 : 0);
        end
        foreach (order[i]) begin
            int w;
            w = order[i];
            rr_last = w;
            g_q.push_back(w);
            if (ops[w] == 2'd0) begin
                rsp_q.push_back(rsp_t'{w, 1'b1, 1});
            end else begin
                x_q.push_back(xfer_t'{CTRL_A, 1'b1, 32'(ops[w])});
                if (werr) begin
                    rsp_q.push_back(rsp_t'{w, 1'b1, 3});
                end else if (va > 0) begin
                    repeat (va) x_q.push_back(xfer_t'{STAT_A, 1'b0, 32'h0});
                    rsp_q.push_back(rsp_t'{w, 1'b0, 5 + (va - 1) * (POLL_GAP + 2)});
                end else begin
                    any_reads = 1'b1;
                    rsp_q.push_back(rsp_t'{w, 1'b1, -1});
                end
            end
        end
        req_op_i = {op1, op0};
        req_valid_i = mask;
        serve(order.size());
        chk("xfers_consumed", 32'(x_q.size()), 32'h0);
        any_reads = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid_i = 2'b11;
        req_op_i = 4'b0101;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("reset_htrans", 32'(htrans_o), 32'h0);
        chk("reset_hsize", 32'(hsize_o), 32'h2);
        chk("reset_req_ready", 32'(req_ready_o), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_hsel", 32'(hsel_o), 32'h0);
        chk("reset_hwrite", 32'(hwrite_o), 32'h0);
        chk("reset_haddr", haddr_o, 32'h0);
        chk("reset_hwdata", hwdata_o, 32'h0);
        do_reset();

        // 1: single KEYGEN, VALID on first poll
        launch(2'b01, 2'd1, 2'd0, 1, 1'b0);
        chk("t1_ctrl_addr", last_wr_addr, 32'h1000_8010);
        chk("t1_ctrl_wdata", last_wr_data, 32'h1);
        chk("t1_latency", 32'(last_lat), 32'd5);
        chk("t1_err", 32'(last_err), 32'h0);

        // 2: contention after reset, then contention again
        do_reset();
        launch(2'b11, 2'd2, 2'd3, 1, 1'b0);
        chk("t2_last_owner", 32'(last_owner), 32'd1);
        launch(2'b11, 2'd1, 2'd1, 1, 1'b0);
        chk("t2b_last_owner", 32'(last_owner), 32'd1);

        // 3: VALID on third poll
        launch(2'b10, 2'd0, 2'd3, 3, 1'b0);
        chk("t3_status_reads", 32'(mon_rds), 32'd3);
        chk("t3_latency", 32'(last_lat), 32'd17);

        // 4: error response on CTRL write
        launch(2'b01, 2'd2, 2'd0, 1, 1'b1);
        chk("t4_status_reads", 32'(mon_rds), 32'd0);
        chk("t4_err", 32'(last_err), 32'h1);
        chk("t4_latency", 32'(last_lat), 32'd3);

        // 5: VALID never set -> timeout
        launch(2'b01, 2'd1, 2'd0, 0, 1'b0);
        chk("t5_err", 32'(last_err), 32'h1);
        @(negedge clk);
        chk("t5_busy_drops", 32'(busy_o), 32'h0);
        @(posedge clk);
        #1;

        // 6: reset during a stalled STATUS data phase
        begin
            int n = 0;
            bit seen = 1'b0;
            logic rdy;
            sl_valid_after = 0;
            sl_wr_err = 1'b0;
            g_q.push_back(0);
            x_q.push_back(xfer_t'{CTRL_A, 1'b1, 32'h1});
            any_reads = 1'b1;
            req_op_i = 4'b0001;
            req_valid_i = 2'b01;
            while (!seen && (n < 50)) begin
                @(negedge clk);
                rdy = req_ready_o[0];
                seen = (htrans_o == 2'b10) && !hwrite_o;
                @(posedge clk);
                #1 if (rdy) req_valid_i[0] = 1'b0;
                n++;
            end
            chk("t6_reached_status_read", 32'(seen), 32'h1);
            hreadyout_i = 1'b0;
            reset = 1'b1;
            flush_model();
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk("t6_htrans_idle", 32'(htrans_o), 32'h0);
            chk("t6_busy", 32'(busy_o), 32'h0);
            chk("t6_no_rsp", 32'(rsp_valid_o), 32'h0);
            @(posedge clk);
            #1 hreadyout_i = 1'b1;
        end

        // 7: illegal op goes straight to error
        launch(2'b10, 2'd1, 2'd0, 1, 1'b0);
        chk("t7_owner", 32'(last_owner), 32'd1);
        chk("t7_err", 32'(last_err), 32'h1);
        chk("t7_latency", 32'(last_lat), 32'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
